// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, LCD command bytes and control-bus bit positions for the LCD write engine.
package lcd_pkg;
  typedef enum logic [2:0] {S_PWR, S_INIT, S_CFG, S_IDLE, S_WRITE} state_t;
  typedef enum logic [1:0] {P_NIB1, P_GAP, P_NIB2, P_SETTLE} phase_t;
  localparam logic [7:0] LCD_FUNC_SET = 8'h28;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam int CTL_RS = 2;
  localparam int CTL_RW = 1;
  localparam int CTL_E  = 0;
  function automatic logic [7:0] cfg_byte(input logic [1:0] i);
    return i == 2'd0 ? LCD_FUNC_SET : i == 2'd1 ? LCD_ENTRY : i == 2'd2 ? LCD_DISP_ON : LCD_CLEAR;
  endfunction
endpackage

// File: rtl/lcd_write_engine_if.sv
// lcd_write_engine_if: write/clear handshake between the display FSM (master) and the LCD engine (slave).
interface lcd_write_engine_if;
  logic       I_WRITE_START;
  logic [7:0] I_DATA;
  logic       I_RS;
  logic       I_CLEAR_ALL;
  logic       O_INIT_DONE;
  logic       O_WRITE_DONE;
  logic       O_BUSY;
  modport master (output I_WRITE_START, I_DATA, I_RS, I_CLEAR_ALL, input O_INIT_DONE, O_WRITE_DONE, O_BUSY);
  modport slave  (input I_WRITE_START, I_DATA, I_RS, I_CLEAR_ALL, output O_INIT_DONE, O_WRITE_DONE, O_BUSY);
endinterface

// File: rtl/lcd_nibble_strobe.sv
// lcd_nibble_strobe: one timed nibble transfer -- data/RS setup, E high, hold; done flags the last hold cycle.
module lcd_nibble_strobe #(
  parameter int T_SETUP = 2,
  parameter int T_EHIGH = 12,
  parameter int T_HOLD  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic [3:0] sf_d,
  output logic       lcd_rs,
  output logic       e,
  output logic       done
);
  localparam logic [15:0] E_ON  = 16'(T_SETUP);
  localparam logic [15:0] E_OFF = 16'(T_SETUP + T_EHIGH);
  localparam logic [15:0] LAST  = 16'(T_SETUP + T_EHIGH + T_HOLD - 1);
  logic        active;
  logic [15:0] cnt, nxt;
  assign nxt  = cnt + 16'd1;
  assign done = active && cnt == LAST;
  // E is registered from the next cycle index so it never glitches on the pin
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sf_d   <= '0;
      lcd_rs <= 1'b0;
      e      <= 1'b0;
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      sf_d   <= nibble;
      lcd_rs <= rs;
      e      <= 1'b0;
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      cnt    <= nxt;
      active <= !done;
      e      <= !done && nxt >= E_ON && nxt < E_OFF;
    end
endmodule

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: power-on init, configuration, byte writes and clear commands for a 4-bit HD44780 LCD.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int T_POWERON    = 750000,
  parameter int T_INIT1      = 205000,
  parameter int T_INIT2      = 5000,
  parameter int T_SETUP      = 2,
  parameter int T_EHIGH      = 12,
  parameter int T_HOLD       = 1,
  parameter int T_NIBBLE_GAP = 50,
  parameter int T_CMD        = 2000,
  parameter int T_CLEAR      = 82000
) (
  input  logic                I_CLK,
  input  logic                I_RST_N,
  lcd_write_engine_if.slave   bus,
  output logic [3:0]          O_SF_D,
  output logic [2:0]          O_CONTROL
);
  function automatic logic [19:0] wait_of(input int n);
    return 20'(n - 1);
  endfunction
  state_t      state, state_d;
  phase_t      phase, phase_d;
  logic [1:0]  step, step_d;
  logic [19:0] wait_cnt, load_val;
  logic [7:0]  cap_byte;
  logic [3:0]  lo_q, n_nib;
  logic        rs_q, long_q, cap_rs, cap_long, clear_pend, init_done, write_done;
  logic        load, cap, done_d, take_clear, n_start, n_rs, n_done, s_rs, s_e;
  wire         wait_zero = wait_cnt == '0;
  lcd_nibble_strobe #(.T_SETUP(T_SETUP), .T_EHIGH(T_EHIGH), .T_HOLD(T_HOLD)) u_strobe (
    .clk(I_CLK), .rst_n(I_RST_N), .start(n_start), .nibble(n_nib), .rs(n_rs),
    .sf_d(O_SF_D), .lcd_rs(s_rs), .e(s_e), .done(n_done)
  );
  // A new byte launches its upper nibble on the same edge that captures it, so no idle cycles
  // appear between consecutive commands or between acceptance and the first nibble.
  always_comb begin
    state_d = state; phase_d = phase; step_d = step;
    n_start = 1'b0; n_nib = 4'h3; n_rs = 1'b0;
    load = 1'b0; load_val = '0;
    cap = 1'b0; cap_byte = LCD_CLEAR; cap_rs = 1'b0; cap_long = 1'b1;
    done_d = 1'b0; take_clear = 1'b0;
    case (state)
      S_PWR: if (wait_zero) begin
        state_d = S_INIT; step_d = '0; phase_d = P_NIB1; n_start = 1'b1;
      end
      S_INIT: if (phase == P_NIB1 && n_done) begin
        phase_d = P_SETTLE; load = 1'b1;
        load_val = step == 2'd0 ? wait_of(T_INIT1) : step == 2'd1 ? wait_of(T_INIT2) : wait_of(T_CMD);
      end else if (phase == P_SETTLE && wait_zero) begin
        phase_d = P_NIB1; n_start = 1'b1;
        if (step == 2'd3) begin
          state_d = S_CFG; step_d = '0; cap = 1'b1; cap_byte = cfg_byte(2'd0); cap_long = 1'b0;
          n_nib = cap_byte[7:4];
        end else begin
          step_d = step + 2'd1; n_nib = step == 2'd2 ? 4'h2 : 4'h3;
        end
      end
      S_IDLE: if (bus.I_CLEAR_ALL || clear_pend || bus.I_WRITE_START) begin
        take_clear = bus.I_CLEAR_ALL || clear_pend;
        state_d = S_WRITE; phase_d = P_NIB1; n_start = 1'b1; cap = 1'b1;
        cap_byte = take_clear ? LCD_CLEAR : bus.I_DATA;
        cap_rs = !take_clear && bus.I_RS;
        cap_long = take_clear;
        n_nib = cap_byte[7:4]; n_rs = cap_rs;
      end
      default: case (phase)
        P_NIB1: if (n_done) begin
          phase_d = P_GAP; load = 1'b1; load_val = wait_of(T_NIBBLE_GAP);
        end
        P_GAP: if (wait_zero) begin
          phase_d = P_NIB2; n_start = 1'b1; n_nib = lo_q; n_rs = rs_q;
        end
        P_NIB2: if (n_done) begin
          phase_d = P_SETTLE; load = 1'b1; load_val = long_q ? wait_of(T_CLEAR) : wait_of(T_CMD);
        end
        default: if (wait_zero) begin
          if (state == S_WRITE || step == 2'd3) begin
            state_d = S_IDLE; done_d = state == S_WRITE && !long_q;
          end else begin
            step_d = step + 2'd1; phase_d = P_NIB1; n_start = 1'b1; cap = 1'b1;
            cap_byte = cfg_byte(step + 2'd1); cap_long = step == 2'd2; n_nib = cap_byte[7:4];
          end
        end
      endcase
    endcase
  end
  always_ff @(posedge I_CLK or negedge I_RST_N)
    if (!I_RST_N) begin
      state      <= S_PWR;
      phase      <= P_NIB1;
      step       <= '0;
      wait_cnt   <= wait_of(T_POWERON);
      lo_q       <= '0;
      rs_q       <= 1'b0;
      long_q     <= 1'b0;
      clear_pend <= 1'b0;
      init_done  <= 1'b0;
      write_done <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      step       <= step_d;
      wait_cnt   <= load ? load_val : wait_cnt - 20'(!wait_zero);
      if (cap) begin
        lo_q   <= cap_byte[3:0];
        rs_q   <= cap_rs;
        long_q <= cap_long;
      end
      clear_pend <= !take_clear && (clear_pend || (bus.I_CLEAR_ALL && init_done));
      init_done  <= init_done || state_d == S_IDLE;
      write_done <= done_d;
    end
  always_comb begin
    O_CONTROL = '0;
    O_CONTROL[CTL_RS] = s_rs;
    O_CONTROL[CTL_RW] = 1'b0;
    O_CONTROL[CTL_E]  = s_e;
  end
  assign bus.O_INIT_DONE  = init_done;
  assign bus.O_WRITE_DONE = write_done;
  assign bus.O_BUSY       = state != S_IDLE;
endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: directed + randomized checks of init, writes, clears and reset against a pulse-level model.
module tb_lcd_write_engine;
  localparam int T_POWERON = 100, T_INIT1 = 40, T_INIT2 = 20, T_CMD = 10, T_CLEAR = 30, T_GAP = 5;
  localparam int T_SETUP = 2, T_EHIGH = 12, T_HOLD = 1;
  localparam int N = T_SETUP + T_EHIGH + T_HOLD;
  localparam int WR_LAT = 2 * N + T_GAP + T_CMD;
  localparam int CLR_BUSY = 2 * N + T_GAP + T_CLEAR;
  localparam int INIT_LAT = T_POWERON + 4 * N + T_INIT1 + T_INIT2 + 2 * T_CMD
                          + 4 * (2 * N + T_GAP) + 3 * T_CMD + T_CLEAR;
  typedef struct packed {logic rs; logic [3:0] nib; logic [7:0] w;} pulse_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] sf_d;
  logic [2:0] ctl;
  lcd_write_engine_if bus();
  lcd_write_engine #(
    .T_POWERON(T_POWERON), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SETUP(T_SETUP),
    .T_EHIGH(T_EHIGH), .T_HOLD(T_HOLD), .T_NIBBLE_GAP(T_GAP), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
  ) dut (.I_CLK(clk), .I_RST_N(rst_n), .bus(bus), .O_SF_D(sf_d), .O_CONTROL(ctl));

  always #5 clk = ~clk;

  int cyc = 0, checks = 0, errors = 0, done_cnt = 0, hi = 0, low = 0, min_low = 100000;
  bit seen = 1'b0, e_prev = 1'b0;
  pulse_t obs_q[$], exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor: records every completed E pulse with its nibble, RS and width
  always @(negedge clk) begin
    if (!rst_n) begin
      e_prev = 1'b0; hi = 0; low = 0; seen = 1'b0;
    end else begin
      if (bus.O_WRITE_DONE) done_cnt++;
      if (ctl[0]) begin
        if (!e_prev && seen && low < min_low) min_low = low;
        hi++;
      end else begin
        if (e_prev) begin
          obs_q.push_back({ctl[2], sf_d, 8'(hi)});
          hi = 0; low = 0; seen = 1'b1;
        end
        low++;
      end
      e_prev = ctl[0];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic r);
    exp_q.push_back({r, b[7:4], 8'(T_EHIGH)});
    exp_q.push_back({r, b[3:0], 8'(T_EHIGH)});
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_init(input bit inject_clear);
    int t0, lat;
    bit got;
    logic [3:0] init_nibs [4];
    init_nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
    rst_n = 1'b1;
    t0 = cyc; got = 1'b0; lat = 0;
    for (int i = 1; i <= 1000 && !got; i++) begin
      bus.I_CLEAR_ALL = inject_clear && i == 50;
      @(negedge clk);
      if (bus.O_INIT_DONE) begin got = 1'b1; lat = cyc - t0; end
    end
    bus.I_CLEAR_ALL = 1'b0;
    check("init_done_seen", got, 1);
    check("init_latency", lat, INIT_LAT);
    check("busy_after_init", bus.O_BUSY, 0);
    foreach (init_nibs[i]) exp_q.push_back({1'b0, init_nibs[i], 8'(T_EHIGH)});
    expect_byte(8'h28, 1'b0);
    expect_byte(8'h06, 1'b0);
    expect_byte(8'h0C, 1'b0);
    expect_byte(8'h01, 1'b0);
    check_pulses("init_seq");
  endtask

  // inj: 0 none, 1 extra write request while busy, 2 two clear requests during the write
  task automatic do_write(input logic [7:0] b, input logic r, input int inj);
    int t0, lat;
    bit got;
    bus.I_WRITE_START = 1'b1; bus.I_DATA = b; bus.I_RS = r;
    @(negedge clk);
    t0 = cyc;
    bus.I_WRITE_START = 1'b0;
    expect_byte(b, r);
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 200 && !got; i++) begin
      bus.I_WRITE_START = inj == 1 && i == 10;
      if (inj == 1 && i == 10) bus.I_DATA = 8'h65;
      bus.I_CLEAR_ALL = inj == 2 && (i == 10 || i == 20);
      @(negedge clk);
      if (bus.O_WRITE_DONE) begin got = 1'b1; lat = cyc - t0; end
    end
    bus.I_WRITE_START = 1'b0; bus.I_CLEAR_ALL = 1'b0;
    check("write_done_seen", got, 1);
    check("write_latency", lat, WR_LAT);
    check("busy_at_done", bus.O_BUSY, 0);
  endtask

  initial begin
    int base, n;
    logic [7:0] b;
    logic r;
    bus.I_WRITE_START = 1'b0; bus.I_DATA = '0; bus.I_RS = 1'b0; bus.I_CLEAR_ALL = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sf_d", sf_d, 0);
    check("rst_control", ctl, 0);
    check("rst_init_done", bus.O_INIT_DONE, 0);
    check("rst_write_done", bus.O_WRITE_DONE, 0);
    check("rst_busy", bus.O_BUSY, 1);
    run_init(1'b0);

    do_write(8'h48, 1'b1, 0);
    check_pulses("write_48");
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      r = 1'($urandom);
      do_write(b, r, 0);
      check_pulses("rand_write");
    end

    repeat (2) @(negedge clk);
    base = done_cnt;
    do_write(8'h41, 1'b1, 1);
    repeat (20) @(negedge clk);
    check("busy_write_done_count", done_cnt, base + 1);
    check_pulses("write_busy");

    base = done_cnt;
    do_write(8'h6C, 1'b1, 2);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.O_BUSY) break;
      n++;
    end
    check("clear_busy_cycles", n, CLR_BUSY);
    expect_byte(8'h01, 1'b0);
    repeat (5) @(negedge clk);
    check("clear_done_count", done_cnt, base + 1);
    check_pulses("write_then_clear");

    repeat (3) @(negedge clk);
    base = done_cnt;
    bus.I_WRITE_START = 1'b1; bus.I_CLEAR_ALL = 1'b1; bus.I_DATA = 8'($urandom); bus.I_RS = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.I_WRITE_START = 1'b0; bus.I_CLEAR_ALL = 1'b0;
      if (!bus.O_BUSY) break;
      n++;
    end
    check("simul_busy_cycles", n, CLR_BUSY);
    expect_byte(8'h01, 1'b0);
    repeat (5) @(negedge clk);
    check("simul_done_count", done_cnt, base);
    check_pulses("simul_clear");

    repeat (3) @(negedge clk);
    base = done_cnt;
    bus.I_WRITE_START = 1'b1; bus.I_DATA = 8'($urandom); bus.I_RS = 1'b1;
    @(negedge clk);
    bus.I_WRITE_START = 1'b0;
    for (int i = 0; i < 50 && !ctl[0]; i++) @(negedge clk);
    check("e_high_before_reset", ctl[0], 1);
    rst_n = 1'b0;
    #1;
    check("reset_e_low", ctl[0], 0);
    check("reset_control", ctl, 0);
    check("reset_sf_d", sf_d, 0);
    check("reset_busy", bus.O_BUSY, 1);
    check("reset_init_done", bus.O_INIT_DONE, 0);
    check("reset_write_done", bus.O_WRITE_DONE, 0);
    repeat (3) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    run_init(1'b1);
    repeat (100) @(negedge clk);
    check("idle_after_reinit", bus.O_BUSY, 0);
    check("reinit_done_count", done_cnt, base);
    check_pulses("no_clear_after_init");
    check("min_e_gap", min_low >= T_GAP, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_write_engine.md
# lcd_write_engine

- Responder end of the LCD write handshake: accepts `I_WRITE_START`/`I_DATA` from a display FSM and returns `O_INIT_DONE`/`O_WRITE_DONE`.
- Drives a 4-bit HD44780-style character LCD through `O_SF_D` and `O_CONTROL`.
- After reset it performs the power-on init and configuration sequence on its own.
- After init it serialises each accepted byte into two timed nibble transfers, and issues display-clear commands on request.

## Interface
Parameters (cycle counts, 50 MHz defaults):
- `T_POWERON`, 750000: wait after reset before the first init nibble (15 ms).
- `T_INIT1`, 205000: wait after the first 0x3 init nibble (4.1 ms).
- `T_INIT2`, 5000: wait after the second 0x3 init nibble (100 us).
- `T_SETUP`, 2: data/RS valid before E rises.
- `T_EHIGH`, 12: E high width.
- `T_HOLD`, 1: data held after E falls.
- `T_NIBBLE_GAP`, 50: gap between the upper and lower nibble of one byte.
- `T_CMD`, 2000: settle after a normal byte, and after init nibbles 3 and 4 (40 us).
- `T_CLEAR`, 82000: settle after the clear command 0x01 (1.64 ms).

Ports:
- `I_CLK`  in  1  system clock.
- `I_RST_N`  in  1  asynchronous, active-low reset.
- `I_WRITE_START`  in  1  request to write `I_DATA`.
- `I_DATA`  in  8  byte to write.
- `I_RS`  in  1  0 = command, 1 = character data.
- `I_CLEAR_ALL`  in  1  request for clear-display command (0x01).
- `O_INIT_DONE`  out  1  init and configuration complete; level.
- `O_WRITE_DONE`  out  1  one-cycle pulse when an accepted write has settled.
- `O_BUSY`  out  1  engine not idle.
- `O_SF_D`  out  4  LCD data nibble.
- `O_CONTROL`  out  3  {RS, RW, E}; RW is always 0.

## Operation
- **Reset values (asynchronous):** `O_SF_D`=0, `O_CONTROL`=0, `O_INIT_DONE`=0, `O_WRITE_DONE`=0, `O_BUSY`=1, state=`S_PWR`.
- **State sequence:** `S_PWR` → `S_INIT` → `S_CFG` → `S_IDLE` ⇄ `S_WRITE`.
- **`S_INIT`:** four single nibbles with RS=0: 0x3, 0x3, 0x3, 0x2. Waits after each are `T_INIT1`, `T_INIT2`, `T_CMD`, `T_CMD`.
- **`S_CFG`:** four full commands with RS=0: 0x28, 0x06, 0x0C, 0x01. The first three settle `T_CMD`; 0x01 settles `T_CLEAR`.
- **Init complete:** `O_INIT_DONE` rises on entry to `S_IDLE` and stays high until reset.
- **`O_BUSY`** is 0 only in `S_IDLE`.
- **Accepting a write:** in `S_IDLE`, `I_WRITE_START`=1 at a clock edge captures `I_DATA` and `I_RS`.
  - Upper nibble transfer, then `T_NIBBLE_GAP`, then lower nibble transfer, then `T_CMD`.
  - Then one-cycle `O_WRITE_DONE` and return to `S_IDLE`.
- **Ignored writes:** `I_WRITE_START` while `O_BUSY`=1 or `O_INIT_DONE`=0 is ignored and produces no `O_WRITE_DONE`.
- **Clear requests:**
  - `I_CLEAR_ALL` at any time after init sets a `clear_pend` flag; requests during init are discarded.
  - In `S_IDLE`, `clear_pend` has priority over `I_WRITE_START`. The engine issues 0x01 (RS=0) with `T_CLEAR` settle and clears the flag.
  - A clear produces no `O_WRITE_DONE`.
  - An `I_WRITE_START` arriving in the same cycle as the clear is taken is dropped.
  - Multiple clear requests while pending collapse into one.
- **Nibble transfer:**
  - `O_SF_D` and RS are driven in cycle 0.
  - E is high for `T_EHIGH` cycles, starting `T_SETUP` cycles later.
  - E then falls and `O_SF_D`/RS are held `T_HOLD` more cycles.
- **Outside transfers:** E=0. `O_SF_D` and RS keep their last value.

## Timing
- Nibble length N = `T_SETUP`+`T_EHIGH`+`T_HOLD` = 15 cycles by default.
- **Write latency:** `O_WRITE_DONE` is high exactly 2N+`T_NIBBLE_GAP`+`T_CMD` cycles after the accepting edge (2080 by default). `O_BUSY` falls in the same cycle.
- **Back-to-back writes:** the next write can be accepted in the cycle after `O_WRITE_DONE`.
- **Clear latency:** `O_BUSY` stays high 2N+`T_NIBBLE_GAP`+`T_CLEAR` cycles.
- **E pulses:** the E high period is exactly `T_EHIGH` consecutive cycles. There are never two E pulses closer than `T_NIBBLE_GAP`.
- **Reset mid-operation:** E goes low asynchronously with reset assertion. The sequence restarts from `S_PWR`, and any pending write or clear is lost.
- **Wait counter:** 20 bits. All waits count exactly their parameter value; a value of 0 is not supported.

## Structure
- **Package `lcd_pkg`:**
  - state enum;
  - command constants `LCD_FUNC_SET`=0x28, `LCD_ENTRY`=0x06, `LCD_DISP_ON`=0x0C, `LCD_CLEAR`=0x01;
  - `O_CONTROL` bit indices `CTL_RS`=2, `CTL_RW`=1, `CTL_E`=0.
- **Sub-module `lcd_nibble_strobe`:**
  - inputs: start, nibble, rs;
  - outputs: sf_d, rs, e, done;
  - implements the setup / E-high / hold timing.
- **Top FSM:** sequences init, configuration and byte writes around one shared wait counter.

## Test plan
All scenarios use parameters `T_POWERON`=100, `T_INIT1`=40, `T_INIT2`=20, `T_CMD`=10, `T_CLEAR`=30, `T_NIBBLE_GAP`=5, others default.

1. **Reset and init:** release `I_RST_N`.
   - Observe the E-pulse nibble sequence 3,3,3,2,2,8,0,6,0,C,0,1 with RS=0.
   - `O_INIT_DONE` rises after the 0x01 settle; `O_BUSY`→0.
2. **Data write:** write 0x48 with RS=1.
   - Nibbles 0x4 then 0x8, each with 12-cycle E high and RS=1.
   - `O_WRITE_DONE` pulses exactly 2·15+5+10=45 cycles after acceptance.
3. **Write while busy:** pulse `I_WRITE_START` with 0x65 mid-write.
   - Ignored: no extra E pulses and exactly one `O_WRITE_DONE`.
4. **Clear during a write:** assert `I_CLEAR_ALL` during a write of 0x6C.
   - Write completes with `O_WRITE_DONE`; a 0x0/0x1 RS=0 clear follows.
   - `O_BUSY` stays high 65 more cycles; no second `O_WRITE_DONE`.
5. **Simultaneous write and clear in idle:** assert `I_CLEAR_ALL` and `I_WRITE_START` in the same idle cycle.
   - Only the clear is issued; the write is dropped.
6. **Reset mid-transfer:** assert `I_RST_N`=0 while E=1.
   - E=0 immediately; all outputs take reset values; the init sequence restarts from the beginning.
